// File: rtl/mult32s_rr_scheduler.sv
// ----------------------------------------------------------------------------
// mult32s_normal_ripple
//   Combinational signed 32x32 -> 64 multiplier built from 32 shifted partial
//   products, each accumulated through a 64-bit ripple-carry adder.
//   Ports:
//     a_i       : 32-bit two's complement multiplicand
//     b_i       : 32-bit two's complement multiplier
//     product_o : full 64-bit signed product
//
// mult32s_rr_scheduler
//   Shares one mult32s_normal_ripple between NUM_REQ valid/ready requesters.
//   A round-robin arbiter feeds a two-stage stallable pipeline: stage 0 holds
//   the granted operands, stage 1 holds the product. Results return in issue
//   order on a single valid/ready channel, tagged with the requester index.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     req_valid    : per-requester request valid
//     req_ready    : per-requester grant (one-hot or zero)
//     req_a, req_b : packed operands, requester i at bits [32i+31:32i]
//     res_valid    : result valid
//     res_ready    : result consumer ready
//     res_product  : signed 64-bit product
//     res_id       : index of the requester that issued the operation
// ----------------------------------------------------------------------------

module mult32s_normal_ripple (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] product_o
);

    logic [63:0] a_ext;
    logic [63:0] acc;
    logic [63:0] pp;
    logic [63:0] sum;
    logic        carry;

    assign a_ext = {{32{a_i[31]}}, a_i};

    always_comb begin
        acc   = '0;
        pp    = '0;
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < 32; i++) begin
            pp = b_i[i] ? (a_ext << i) : 64'd0;
            // Bit 31 of b weighs -2^31, so that row is subtracted: acc + ~pp + 1.
            if (i == 31) begin
                pp    = ~pp;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            for (int j = 0; j < 64; j++) begin
                sum[j] = acc[j] ^ pp[j] ^ carry;
                carry  = (acc[j] & pp[j]) | (carry & (acc[j] ^ pp[j]));
            end
            acc = sum;
        end
    end

    assign product_o = acc;

endmodule

module mult32s_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [63:0]           res_product,
    output logic [IDW-1:0]        res_id
);

    // Stage 0: granted operands
    logic           s0_valid_q, s0_valid_d;
    logic [31:0]    s0_a_q, s0_a_d;
    logic [31:0]    s0_b_q, s0_b_d;
    logic [IDW-1:0] s0_id_q, s0_id_d;

    // Stage 1: product
    logic           s1_valid_q, s1_valid_d;
    logic [63:0]    s1_product_q, s1_product_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;

    // Round-robin search start
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic           s1_en;
    logic           s0_en;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand_idx;
    logic [31:0]    cand;
    logic           xfer;
    logic [63:0]    mult_product;

    // ------------------------------------------------------------------
    // Pipeline enables: a stage may load when it is empty or its contents
    // move on in the same edge.
    // ------------------------------------------------------------------
    assign s1_en = !s1_valid_q || res_ready;
    assign s0_en = !s0_valid_q || s1_en;

    // ------------------------------------------------------------------
    // Arbiter: first valid requester at or after rr_ptr, wrapping. It only
    // feeds the stage 0 registers, so it never lengthens the multiplier path.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + 32'(k);
            // rr_ptr_q < NUM_REQ, so a single subtraction completes the modulo
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDW'(cand);
            if (!gnt_any && req_valid[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (s0_en && gnt_any && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = s0_en && gnt_any && !rst;

    // ------------------------------------------------------------------
    // Shared multiplier between stage 0 and stage 1
    // ------------------------------------------------------------------
    mult32s_normal_ripple u_mult (
        .a_i       (s0_a_q),
        .b_i       (s0_b_q),
        .product_o (mult_product)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_a_d     = s0_a_q;
        s0_b_d     = s0_b_q;
        s0_id_d    = s0_id_q;
        if (s0_en) begin
            s0_valid_d = gnt_any;
            if (gnt_any) begin
                s0_a_d  = req_a[32*gnt_idx +: 32];
                s0_b_d  = req_b[32*gnt_idx +: 32];
                s0_id_d = gnt_idx;
            end
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_product_d = s1_product_q;
        s1_id_d      = s1_id_q;
        if (s1_en) begin
            s1_valid_d = s0_valid_q;
            // Product and id only change when a real operation moves in
            if (s0_valid_q) begin
                s1_product_d = mult_product;
                s1_id_d      = s0_id_q;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (gnt_idx == IDW'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q   <= 1'b0;
            s0_a_q       <= '0;
            s0_b_q       <= '0;
            s0_id_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_product_q <= '0;
            s1_id_q      <= '0;
            rr_ptr_q     <= '0;
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_a_q       <= s0_a_d;
            s0_b_q       <= s0_b_d;
            s0_id_q      <= s0_id_d;
            s1_valid_q   <= s1_valid_d;
            s1_product_q <= s1_product_d;
            s1_id_q      <= s1_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign res_valid   = s1_valid_q;
    assign res_product = s1_product_q;
    assign res_id      = s1_id_q;

endmodule

// File: tb/tb_mult32s_rr_scheduler.sv
// Directed and random stimulus for mult32s_rr_scheduler with a scoreboard:
// every transfer pushes its expected {id, product}; every consumed result pops
// and compares.

module tb_mult32s_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [63:0]           res_product;
    logic [IDW-1:0]        res_id;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [63:0]    prod;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          n_res = 0;
    logic [31:0] a_arr [NUM_REQ];
    logic [31:0] b_arr [NUM_REQ];

    always #5 clk = ~clk;

    mult32s_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_id      (res_id)
    );

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[32*i +: 32] = a_arr[i];
            req_b[32*i +: 32] = b_arr[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called at a negedge sample point with res_ready high; retires every
    // pending request as it transfers.
    task automatic release_all();
        logic [NUM_REQ-1:0] xfer;
        int                 n;
        n    = 0;
        xfer = req_valid & req_ready;
        tick();
        req_valid &= ~xfer;
        while (req_valid != '0 && n < 50) begin
            @(negedge clk);
            xfer = req_valid & req_ready;
            tick();
            req_valid &= ~xfer;
            n++;
        end
        check("release_done", 64'(req_valid), 64'd0);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("drain_valid", 64'(res_valid), 64'd0);
        check("drain_sb_empty", 64'(sb_q.size()), 64'd0);
        tick();
    endtask

    // Lone request on an empty pipeline: fixed two-edge latency.
    task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input string tag);
        bit got;
        got       = 1'b0;
        a_arr[id] = a;
        b_arr[id] = b;
        pack();
        req_valid     = '0;
        req_valid[id] = 1'b1;
        res_ready     = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
            else tick();
        end
        check({tag, "_grant"}, 64'(got), 64'd1);
        if (!got) begin
            req_valid = '0;
            return;
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        check({tag, "_lat1"}, 64'(res_valid), 64'd0);
        tick();
        @(negedge clk);
        check({tag, "_lat2"}, 64'(res_valid), 64'd1);
        check({tag, "_prod"}, res_product, exp);
        check({tag, "_id"}, 64'(res_id), 64'(id));
        tick();
    endtask

    // Scoreboard and protocol monitor
    initial begin
        exp_t           e;
        logic           stall_prev;
        logic [63:0]    prod_prev;
        logic [IDW-1:0] id_prev;
        stall_prev = 1'b0;
        prod_prev  = '0;
        id_prev    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                stall_prev = 1'b0;
            end else begin
                total++;
                assert ($onehot0(req_ready)) else begin
                    bad++;
                    $error("FAIL ready_onehot0: observed=%b expected=at most one bit set",
                           req_ready);
                end
                if (stall_prev) begin
                    check("stall_valid", 64'(res_valid), 64'd1);
                    check("stall_prod", res_product, prod_prev);
                    check("stall_id", 64'(res_id), 64'(id_prev));
                end
                if (res_valid && res_ready) begin
                    total++;
                    assert (sb_q.size() != 0) else begin
                        bad++;
                        $error("FAIL sb_underflow: observed=result id %0d expected=no result",
                               res_id);
                    end
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sb_prod", res_product, e.prod);
                        check("sb_id", 64'(res_id), 64'(e.id));
                        n_res++;
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        e.id   = IDW'(i);
                        e.prod = model_prod(req_a[32*i +: 32], req_b[32*i +: 32]);
                        sb_q.push_back(e);
                    end
                end
                stall_prev = res_valid && !res_ready;
                prod_prev  = res_product;
                id_prev    = res_id;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_REQ-1:0] xfer;
        logic [63:0]        held;
        int                 nx;

        rst       = 1'b1;
        req_valid = '1;
        res_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        pack();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_prod", res_product, 64'd0);
        check("rst_id", 64'(res_id), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst       = 1'b0;
        req_valid = '0;

        // Single op from requester 2: -3 * 7
        single_op(2, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "op_neg3x7");

        // Round-robin fairness from a fresh pointer
        rst_pulse();
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = 32'(i * 1000 + 17);
            b_arr[i] = 32'(-(i + 5));
        end
        pack();
        res_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", 64'(req_ready), 64'(1 << (k % 4)));
            if (k >= 2) begin
                check("rr_tput", 64'(res_valid), 64'd1);
                check("rr_res_id", 64'(res_id), 64'((k - 2) % 4));
            end
            tick();
        end
        req_valid = '0;
        drain();

        // Backpressure: two ops fill the pipeline, then everything holds
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = rand_op();
            b_arr[i] = rand_op();
        end
        pack();
        res_ready = 1'b0;
        req_valid = 4'b0011;
        nx        = 0;
        held      = model_prod(a_arr[0], b_arr[0]);
        for (int it = 0; it < 7; it++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) nx += int'(req_valid[i] && req_ready[i]);
            if (it >= 2) begin
                check("bp_ready_zero", 64'(req_ready), 64'd0);
                check("bp_valid", 64'(res_valid), 64'd1);
                check("bp_prod", res_product, held);
                check("bp_id", 64'(res_id), 64'd0);
            end
            tick();
        end
        check("bp_transfers", 64'(nx), 64'd2);
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 64'(req_ready), 64'b0001);
        check("bp_release_id", 64'(res_id), 64'd0);
        release_all();
        drain();

        // Extreme operands
        single_op(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "ext_min_min");
        single_op(1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "ext_max_min");
        single_op(3, 32'h0000_0000, 32'h1234_5678, 64'h0, "ext_zero");
        single_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, "ext_m1_m1");

        // Reset while both stages are full and stalled
        res_ready = 1'b0;
        req_valid = 4'b0011;
        for (int it = 0; it < 3; it++) begin
            @(negedge clk);
            if (it == 2) begin
                check("mid_full_valid", 64'(res_valid), 64'd1);
                check("mid_full_ready", 64'(req_ready), 64'd0);
            end
            tick();
        end
        rst       = 1'b1;
        req_valid = '1;
        tick();
        @(negedge clk);
        check("mid_rst_valid", 64'(res_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst       = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("mid_ptr_first", 64'(req_ready), 64'b0001);
        check("mid_no_stale", 64'(res_valid), 64'd0);
        release_all();
        drain();

        // Random soak
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            xfer = req_valid & req_ready;
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    a_arr[i]     = rand_op();
                    b_arr[i]     = rand_op();
                    req_valid[i] = 1'b1;
                end
            end
            pack();
            res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        release_all();
        drain();
        check("soak_results", 64'(n_res > 1000), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult32s_rr_scheduler.md
# mult32s_rr_scheduler

Round-robin scheduler that shares one `mult32s_normal_ripple` signed 32x32 multiplier between `NUM_REQ` independent requesters. It arbitrates valid/ready request channels and feeds a two-stage stallable pipeline (operand register, product register) around the combinational multiplier. It returns each 64-bit product on a single result channel, tagged with the requester index. It sits between the multiplier characterization/benchmark harness and any client logic that needs shared multiply throughput.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `IDW`, default `$clog2(NUM_REQ)`: width of the requester tag.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `req_valid`  input  NUM_REQ: per-requester request valid.
- `req_ready`  output  NUM_REQ: per-requester grant; one-hot or zero.
- `req_a`  input  NUM_REQ*32: multiplicands, requester i at bits [32i+31:32i], two's complement.
- `req_b`  input  NUM_REQ*32: multipliers, same packing.
- `res_valid`  output  1: result valid.
- `res_ready`  input  1: result consumer ready.
- `res_product`  output  64: signed product.
- `res_id`  output  IDW: index of the requester that issued the operation.

## Operation
- **Datapath**
  - Stage 0 registers `s0_valid`, `s0_a`, `s0_b`, `s0_id`.
  - `s0_a`/`s0_b` drive the `mult32s_normal_ripple` instance combinationally.
  - Stage 1 registers `s1_valid` (drives `res_valid`), `s1_product` (drives `res_product`) and `s1_id` (drives `res_id`).
- **Arithmetic**
  - Full signed 64-bit product, no truncation or saturation.
  - Example: 0x8000_0000 * 0x8000_0000 = 0x4000_0000_0000_0000.
- **Pipeline enables**
  - `s1_en = !s1_valid || res_ready`.
  - `s0_en = !s0_valid || s1_en`.
  - When `s1_en` is high, stage 1 loads `s0_valid` and the `s0` product and id.
  - When `s0_en` is high, stage 0 loads the granted request, or `s0_valid <= 0` if no request is granted.
- **Arbitration**
  - Combinational. When `s0_en`=1, grant the first i with `req_valid[i]`=1, searching from `rr_ptr` upward modulo NUM_REQ.
  - `req_ready[i]` = that grant.
  - If `s0_en`=0, `req_ready` is all zero.
  - `req_ready` depends on `req_valid` and `res_ready` only through this logic.
  - A transfer occurs on the edge where `req_valid[i] && req_ready[i]`.
- **Pointer**
  - On a transfer from requester g, `rr_ptr <= (g+1) mod NUM_REQ`.
  - With no transfer, `rr_ptr` holds.
  - Effect: a continuously requesting client waits at most NUM_REQ-1 grants.
- **Requester obligations**
  - Once `req_valid[i]` is asserted, the requester holds it and its operands stable until transfer.
  - The block does not check this.
- **Result channel**
  - While `res_valid && !res_ready`, `res_product` and `res_id` hold stable.
  - Results leave in issue order; no reordering.
- **Reset**
  - Values: `s0_valid`=0, `s1_valid`=0, `rr_ptr`=0, `s1_product`=0, `s1_id`=0.
  - Resulting outputs: `res_valid`=0, `res_product`=0, `res_id`=0.
  - `req_ready` is all zero while `rst` is high.
  - Reset mid-operation discards all in-flight operations silently; no result is produced for them.

## Timing
- Latency: a request transferred at edge N produces `res_valid`=1 after edge N+1, i.e. it is visible in cycle N+1.
- Throughput: one operation per cycle while `res_ready`=1.
- **Stall**
  - With `res_ready` low, the pipeline holds at most 2 operations.
  - Once both stages are full, `req_ready` is zero until `res_ready` rises.
  - On the cycle `res_ready` rises, a new grant is allowed; the pipeline advances in the same edge.
- **Simultaneous events**
  - Result drain and new accept in the same cycle are both performed.
  - Several `req_valid` rising together resolve by `rr_ptr` order.
- The critical path includes the combinational multiplier between stage 0 and stage 1 only. Arbitration logic must not sit in series with the multiplier.

## Test plan
- **Reset and single op**
  - Assert `rst` for 2 cycles; expect all outputs 0.
  - Requester 2 issues a=-3 (0xFFFF_FFFD), b=7.
  - Expect `res_valid` 2 cycles after transfer, `res_product`=0xFFFF_FFFF_FFFF_FFEB, `res_id`=2.
- **Round-robin fairness**
  - NUM_REQ=4, all requesters continuously valid, `res_ready`=1.
  - Expect grant order 0,1,2,3,0,1… with one result per cycle and `res_id` following the same order.
- **Backpressure**
  - Hold `res_ready`=0 with requesters 0 and 1 valid.
  - Expect exactly 2 transfers, then `req_ready`=0 and the result stable for 5 cycles.
  - Release `res_ready`; expect both results in issue order with no loss or duplication.
- **Extreme operands**
  - 0x8000_0000*0x8000_0000 -> 0x4000_0000_0000_0000.
  - 0x7FFF_FFFF*0x8000_0000 -> 0xC000_0000_8000_0000.
  - 0*x -> 0.
- **Reset mid-operation**
  - Assert `rst` while both stages are full and `res_ready`=0.
  - Expect `res_valid`=0 the next cycle, no stale result afterwards, and `rr_ptr` restart with requester 0 first.
- **Random soak**
  - 10k cycles with random `req_valid` and `res_ready`.
  - Scoreboard per requester: every transferred operation returns exactly once, in order, with correct product and id.
